// File: rtl/sc_et_controller.sv
`default_nettype none
// ============================================================================
// Module   : sc_et_controller
// Brief    : Sequencer for one stochastic-computing evaluation: seeds/steps an
//            LFSR SNG bank, counts output 1s, optional progressive early stop.
// Revision : 1.0 - initial release
// ============================================================================
module sc_et_controller #(
    parameter int WIDTH       = 8,
    parameter int NUM_INPUTS  = 8,
    parameter int ET_MIN_LOG2 = 4,
    parameter int ET_TOL      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic [NUM_INPUTS*WIDTH-1:0] start_bxs,
    input  logic                        et_en,
    input  logic                        abort,
    output logic                        sng_load,
    output logic                        sng_en,
    output logic [NUM_INPUTS*WIDTH-1:0] sng_bxs,
    input  logic                        sc_bit,
    output logic                        busy,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [WIDTH-1:0]            result,
    output logic [WIDTH-1:0]            res_len,
    output logic                        res_early
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEED = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_tol = WIDTH'(ET_TOL);

    state_t           r_state;
    logic             r_et_en;
    logic [WIDTH-1:0] r_cyc_cnt;
    logic [WIDTH-1:0] r_ones_cnt;
    logic [WIDTH-1:0] r_prev_est;

    logic [WIDTH-1:0] w_n;
    logic [WIDTH-1:0] w_ones_n;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_est;
    logic [WIDTH-1:0] w_diff;
    logic             w_ckpt;
    logic             w_first;
    logic             w_early;
    logic             w_full;

    assign w_n      = r_cyc_cnt + c_one;
    assign w_ones_n = r_ones_cnt + {{(WIDTH-1){1'b0}}, sc_bit};

    // Checkpoints sit at n = 2^k; the extra bit catches ones_n = 2^k, which saturates.
    always_comb begin
        w_ckpt    = 1'b0;
        w_first   = 1'b0;
        w_shifted = '0;
        for (int k = ET_MIN_LOG2; k <= WIDTH - 1; k++) begin
            if (w_n == (c_one << k)) begin
                w_ckpt    = 1'b1;
                w_first   = (k == ET_MIN_LOG2);
                w_shifted = {1'b0, w_ones_n} << (WIDTH - k);
            end
        end
    end

    assign w_est   = w_shifted[WIDTH] ? {WIDTH{1'b1}} : w_shifted[WIDTH-1:0];
    assign w_diff  = (w_est >= r_prev_est) ? (w_est - r_prev_est) : (r_prev_est - w_est);
    assign w_early = r_et_en & w_ckpt & ~w_first & (w_diff <= c_tol);
    assign w_full  = (w_n == {WIDTH{1'b1}});

    assign start_ready = (r_state == S_IDLE);
    assign sng_load    = (r_state == S_SEED);
    assign sng_en      = (r_state == S_RUN);
    assign busy        = (r_state == S_SEED) || (r_state == S_RUN);
    assign res_valid   = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_et_en    <= 1'b0;
            r_cyc_cnt  <= '0;
            r_ones_cnt <= '0;
            r_prev_est <= '0;
            sng_bxs    <= '0;
            result     <= '0;
            res_len    <= '0;
            res_early  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        sng_bxs <= start_bxs;
                        r_et_en <= et_en;
                        r_state <= S_SEED;
                    end
                end
                S_SEED: begin
                    r_cyc_cnt  <= '0;
                    r_ones_cnt <= '0;
                    r_prev_est <= '0;
                    r_state    <= abort ? S_IDLE : S_RUN;
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cyc_cnt  <= w_n;
                        r_ones_cnt <= w_ones_n;
                        if (r_et_en && w_ckpt) begin
                            r_prev_est <= w_est;
                        end
                        if (w_early) begin
                            result    <= w_est;
                            res_len   <= w_n;
                            res_early <= 1'b1;
                            r_state   <= S_DONE;
                        end else if (w_full) begin
                            result    <= w_ones_n;
                            res_len   <= w_n;
                            res_early <= 1'b0;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sc_et_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_et_controller
// Brief    : Directed self-checking bench for sc_et_controller (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_et_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [63:0] start_bxs = '0;
    logic        et_en = 1'b0;
    logic        abort = 1'b0;
    logic        sng_load;
    logic        sng_en;
    logic [63:0] sng_bxs;
    logic        sc_bit = 1'b0;
    logic        busy;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  result;
    logic [7:0]  res_len;
    logic        res_early;

    int n_pass = 0;
    int n_total = 0;

    sc_et_controller #(
        .WIDTH(8), .NUM_INPUTS(8), .ET_MIN_LOG2(4), .ET_TOL(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_bxs(start_bxs), .et_en(et_en), .abort(abort),
        .sng_load(sng_load), .sng_en(sng_en), .sng_bxs(sng_bxs),
        .sc_bit(sc_bit), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .res_len(res_len), .res_early(res_early)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic pattern(input int mode, input int idx);
        case (mode)
            0:       return 1'b1;
            1:       return (idx % 2) == 0;
            default: return idx < 16;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a job and runs it to DONE; t_valid is cycles from accept edge to res_valid.
    task automatic run_job(input int mode, input logic et, input logic [63:0] bxs,
                           output int t_valid, output int en_cycles, output int load_cycles);
        int t;
        int idx;
        start_valid = 1'b1;
        start_bxs   = bxs;
        et_en       = et;
        step();
        start_valid = 1'b0;
        et_en       = 1'b0;
        t = 1; idx = 0; en_cycles = 0; load_cycles = 0; t_valid = -1;
        while (t < 400 && t_valid < 0) begin
            if (sng_load) load_cycles++;
            if (res_valid) begin
                t_valid = t;
            end else begin
                if (sng_en) begin
                    en_cycles++;
                    sc_bit = pattern(mode, idx);
                    idx++;
                end
                step();
                t++;
            end
        end
        sc_bit = 1'b0;
    endtask

    task automatic ack();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        int tv, en, ld;
        logic stable;
        logic [7:0] r0, l0;
        logic e0;

        #12;
        chk("reset_start_ready", 64'(start_ready), 64'd1);
        chk("reset_busy_en_load", {61'd0, busy, sng_en, sng_load}, 64'd0);
        chk("reset_res_valid", 64'(res_valid), 64'd0);
        chk("reset_result_len", {47'd0, res_early, res_len, result}, 64'd0);
        chk("reset_sng_bxs", sng_bxs, 64'd0);
        rst_n = 1'b1;
        step();

        // Full-length job, no early termination
        run_job(0, 1'b0, 64'hDEAD_BEEF_0123_4567, tv, en, ld);
        chk("full_latency", 64'(tv), 64'd257);
        chk("full_result", 64'(result), 64'd255);
        chk("full_len", 64'(res_len), 64'd255);
        chk("full_early", 64'(res_early), 64'd0);
        chk("full_en_cycles", 64'(en), 64'd255);
        chk("full_load_cycles", 64'(ld), 64'd1);
        chk("full_bxs", sng_bxs, 64'hDEAD_BEEF_0123_4567);
        chk("done_not_ready", {62'd0, start_ready, busy}, 64'd0);
        ack();
        chk("ack_start_ready", {62'd0, start_ready, res_valid}, 64'd2);

        // Alternating stream terminates at n=32
        run_job(1, 1'b1, 64'h1111_2222_3333_4444, tv, en, ld);
        chk("alt_latency", 64'(tv), 64'd34);
        chk("alt_result", 64'(result), 64'd128);
        chk("alt_len", 64'(res_len), 64'd32);
        chk("alt_early", 64'(res_early), 64'd1);
        ack();

        // All-ones stream saturates both early estimates
        run_job(0, 1'b1, 64'h5555_6666_7777_8888, tv, en, ld);
        chk("sat_latency", 64'(tv), 64'd34);
        chk("sat_result", 64'(result), 64'd255);
        chk("sat_len", 64'(res_len), 64'd32);
        chk("sat_early", 64'(res_early), 64'd1);
        ack();

        // Estimates keep diverging: full length
        run_job(2, 1'b1, 64'h0, tv, en, ld);
        chk("div_latency", 64'(tv), 64'd257);
        chk("div_result", 64'(result), 64'd16);
        chk("div_len", 64'(res_len), 64'd255);
        chk("div_early", 64'(res_early), 64'd0);
        ack();

        // Abort at RUN cycle 10
        start_valid = 1'b1;
        start_bxs   = 64'h0706_0504_0302_0100;
        step();
        start_valid = 1'b0;
        step();
        chk("abort_in_run", 64'(sng_en), 64'd1);
        repeat (9) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle", {61'd0, start_ready, busy, res_valid}, 64'd4);
        chk("abort_bxs", sng_bxs, 64'h0706_0504_0302_0100);
        step();
        chk("abort_no_result", 64'(res_valid), 64'd0);

        // Restart reseeds, then hold DONE for 20 cycles
        run_job(1, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5, tv, en, ld);
        chk("restart_load", 64'(ld), 64'd1);
        chk("restart_result", 64'(result), 64'd128);
        r0 = result; l0 = res_len; e0 = res_early;
        stable = 1'b1;
        abort = 1'b1;
        repeat (20) begin
            step();
            if (!res_valid || start_ready || result !== r0 || res_len !== l0 || res_early !== e0)
                stable = 1'b0;
        end
        abort = 1'b0;
        chk("done_hold_stable", 64'(stable), 64'd1);
        ack();

        // Reset mid-RUN
        start_valid = 1'b1;
        start_bxs   = 64'hFFFF_0000_FFFF_0000;
        step();
        start_valid = 1'b0;
        repeat (20) step();
        chk("mid_run_en", 64'(sng_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_en_busy", {62'd0, sng_en, busy}, 64'd0);
        chk("rst_mid_ready", {62'd0, start_ready, res_valid}, 64'd2);
        chk("rst_mid_result", {47'd0, res_early, res_len, result}, 64'd0);
        chk("rst_mid_bxs", sng_bxs, 64'd0);
        #10 rst_n = 1'b1;
        step();
        chk("post_rst_idle", {62'd0, start_ready, sng_load}, 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
